// File: rtl/button_conditioner.sv
// Push-button front end: per channel a 2-FF synchronizer, integrating debouncer,
// press pulse generator and auto-repeat FSM; channels are fully independent.
module button_conditioner #(
    parameter int                   NUM_BTN      = 3,
    parameter int                   DEBOUNCE_CYC = 1_000_000,
    parameter int                   HOLD_CYC     = 25_000_000,
    parameter int                   REPEAT_CYC   = 5_000_000,
    parameter logic [NUM_BTN-1:0]   REPEAT_MASK  = 3'b110,
    parameter int                   CNT_W        = 25
) (
    input  logic               CLK_50MHZ,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_pulse
);

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } state_t;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BTN; gi++) begin : g_chan
            logic             s1_q, s2_q;
            logic             stable_q, stable_d;
            logic [CNT_W-1:0] dcnt_q, dcnt_d;
            logic [CNT_W-1:0] hcnt_q, hcnt_d;
            state_t           state_q, state_d;
            logic             pulse_q, pulse_d;
            logic             rise, fall;

            // The FSM reacts to the accepted level changing at this very edge, so that
            // the first press pulse lines up with btn_level first reading 1.
            assign rise = stable_d & ~stable_q;
            assign fall = ~stable_d & stable_q;

            always_ff @(posedge CLK_50MHZ or negedge reset) begin
                if (!reset) begin
                    s1_q     <= 1'b0;
                    s2_q     <= 1'b0;
                    stable_q <= 1'b0;
                    dcnt_q   <= '0;
                    hcnt_q   <= '0;
                    state_q  <= IDLE;
                    pulse_q  <= 1'b0;
                end else begin
                    s1_q     <= btn_raw[gi];
                    s2_q     <= s1_q;
                    stable_q <= stable_d;
                    dcnt_q   <= dcnt_d;
                    hcnt_q   <= hcnt_d;
                    state_q  <= state_d;
                    pulse_q  <= pulse_d;
                end
            end

            always_comb begin
                stable_d = stable_q;
                dcnt_d   = dcnt_q;
                if (s2_q == stable_q) begin
                    dcnt_d = '0;
                end else if (dcnt_q == DEB_LAST) begin
                    stable_d = s2_q;
                    dcnt_d   = '0;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end

            always_comb begin
                state_d = state_q;
                hcnt_d  = hcnt_q;
                case (state_q)
                    IDLE: begin
                        if (rise) begin
                            state_d = HOLD;
                            hcnt_d  = '0;
                        end
                    end
                    HOLD: begin
                        // Channels without auto-repeat park here with hcnt saturated.
                        if (hcnt_q == HOLD_LAST) begin
                            if (REPEAT_MASK[gi]) begin
                                state_d = REPEAT;
                                hcnt_d  = '0;
                            end
                        end else begin
                            hcnt_d = hcnt_q + 1'b1;
                        end
                    end
                    REPEAT: begin
                        if (hcnt_q == REP_LAST) hcnt_d = '0;
                        else                    hcnt_d = hcnt_q + 1'b1;
                    end
                    default: begin
                        state_d = IDLE;
                        hcnt_d  = '0;
                    end
                endcase
                if (fall) begin
                    state_d = IDLE;
                    hcnt_d  = '0;
                end
            end

            always_comb begin
                pulse_d = 1'b0;
                case (state_q)
                    IDLE:    pulse_d = rise;
                    HOLD:    pulse_d = ~fall & REPEAT_MASK[gi] & (hcnt_q == HOLD_LAST);
                    REPEAT:  pulse_d = ~fall & (hcnt_q == REP_LAST);
                    default: pulse_d = 1'b0;
                endcase
            end

            assign btn_level[gi] = stable_q;
            assign btn_pulse[gi] = pulse_q;
        end
    endgenerate

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: stimulus pushes expected pulse cycles into a
// scoreboard queue; a negedge monitor pops and compares whenever a pulse is due or seen.
module tb_button_conditioner;

    localparam int DEB  = 4;
    localparam int HOLD = 10;
    localparam int REP  = 3;

    typedef struct {
        int         cyc;
        logic [2:0] vec;
    } sb_entry_t;

    logic       clk;
    logic       rst_n;
    logic [2:0] btn_raw;
    logic [2:0] btn_level;
    logic [2:0] btn_pulse;

    int        cyc    = 0;
    int        checks = 0;
    int        errors = 0;
    sb_entry_t sb[$];
    sb_entry_t ent;

    button_conditioner #(
        .NUM_BTN     (3),
        .DEBOUNCE_CYC(DEB),
        .HOLD_CYC    (HOLD),
        .REPEAT_CYC  (REP),
        .REPEAT_MASK (3'b110),
        .CNT_W       (25)
    ) dut (
        .CLK_50MHZ(clk),
        .reset    (rst_n),
        .btn_raw  (btn_raw),
        .btn_level(btn_level),
        .btn_pulse(btn_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: cyc holds the index of the most recent rising edge.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            ent = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL pulse_missed cycle %0d got none want %b", ent.cyc, ent.vec);
        end
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            ent = sb.pop_front();
            checks++;
            if (btn_pulse !== ent.vec) begin
                errors++;
                $display("FAIL pulse cycle %0d got %b want %b", cyc, btn_pulse, ent.vec);
            end else begin
                $display("pulse  cycle %0d vec %b ok", cyc, btn_pulse);
            end
        end else if (btn_pulse !== 3'b000) begin
            checks++;
            errors++;
            $display("FAIL pulse_unexpected cycle %0d got %b want 000", cyc, btn_pulse);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic to_edge(input int e);
        while (cyc < e) step();
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic push(input int c, input logic [2:0] v);
        sb_entry_t x;
        x.cyc = c;
        x.vec = v;
        sb.push_back(x);
    endtask

    task automatic chk(input string name, input logic [2:0] got, input logic [2:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cycle %0d got %b want %b", name, cyc, got, want);
        end else begin
            $display("check  %s cycle %0d value %b ok", name, cyc, got);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cycle %0d got timeout want finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        btn_raw = 3'b000;
        rst_n   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_level", btn_level, 3'b000);
        chk("reset_pulse", btn_pulse, 3'b000);
        rst_n = 1'b1;
        idle(4);

        // 1: ch0 press, no auto-repeat
        r = cyc;
        push(r + 6, 3'b001);
        btn_raw = 3'b001;
        to_edge(r + 5);  chk("t1_level_pre", btn_level, 3'b000);
        to_edge(r + 6);  chk("t1_level_rise", btn_level, 3'b001);
        to_edge(r + 20); btn_raw = 3'b000;
        to_edge(r + 25); chk("t1_level_held", btn_level, 3'b001);
        to_edge(r + 26); chk("t1_level_fall", btn_level, 3'b000);
        idle(10);

        // 2: ch1 held, auto-repeat
        r = cyc;
        push(r + 6,  3'b010);
        push(r + 16, 3'b010);
        push(r + 19, 3'b010);
        push(r + 22, 3'b010);
        push(r + 25, 3'b010);
        btn_raw = 3'b010;
        to_edge(r + 20); btn_raw = 3'b000;
        to_edge(r + 25); chk("t2_level_held", btn_level, 3'b010);
        to_edge(r + 26); chk("t2_level_fall", btn_level, 3'b000);
        idle(10);

        // 3: ch2 glitch of 3 cycles is rejected
        r = cyc;
        btn_raw = 3'b100;
        to_edge(r + 3); btn_raw = 3'b000;
        for (int k = 4; k <= 12; k++) begin
            to_edge(r + k);
            chk("t3_glitch_level", btn_level, 3'b000);
        end
        idle(5);

        // 4: ch1 bounce, final rising edge after edge r+8
        r = cyc;
        push(r + 14, 3'b010);
        btn_raw = 3'b010;
        to_edge(r + 2);  btn_raw = 3'b000;
        to_edge(r + 4);  btn_raw = 3'b010;
        to_edge(r + 6);  btn_raw = 3'b000;
        to_edge(r + 8);  btn_raw = 3'b010;
        to_edge(r + 13); chk("t4_level_pre", btn_level, 3'b000);
        to_edge(r + 14); chk("t4_level_rise", btn_level, 3'b010);
        to_edge(r + 16); btn_raw = 3'b000;
        to_edge(r + 22); chk("t4_level_fall", btn_level, 3'b000);
        idle(10);

        // 5: reset while ch1 is held; re-press after reset release
        r = cyc;
        push(r + 6,  3'b010);
        push(r + 16, 3'b010);
        push(r + 25, 3'b010);
        push(r + 35, 3'b010);
        push(r + 38, 3'b010);
        push(r + 41, 3'b010);
        push(r + 44, 3'b010);
        btn_raw = 3'b010;
        to_edge(r + 16);
        chk("t5_level_before_rst", btn_level, 3'b010);
        chk("t5_pulse_before_rst", btn_pulse, 3'b010);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t5_level_async_rst", btn_level, 3'b000);
        chk("t5_pulse_async_rst", btn_pulse, 3'b000);
        to_edge(r + 18); chk("t5_level_in_rst", btn_level, 3'b000);
        to_edge(r + 19); rst_n = 1'b1;
        to_edge(r + 24); chk("t5_level_pre", btn_level, 3'b000);
        to_edge(r + 25); chk("t5_level_rise", btn_level, 3'b010);
        to_edge(r + 39); btn_raw = 3'b000;
        to_edge(r + 45); chk("t5_level_fall", btn_level, 3'b000);
        idle(10);

        // 6: ch1 and ch2 pressed together
        r = cyc;
        push(r + 6,  3'b110);
        push(r + 16, 3'b110);
        push(r + 19, 3'b110);
        btn_raw = 3'b110;
        to_edge(r + 6);  chk("t6_level_rise", btn_level, 3'b110);
        to_edge(r + 14); btn_raw = 3'b000;
        to_edge(r + 19); chk("t6_level_held", btn_level, 3'b110);
        to_edge(r + 20); chk("t6_level_fall", btn_level, 3'b000);
        idle(8);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
